gray_sync_decoder: RTL
======================

GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Gray/binary code width in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, minimum 2, giving the depth of the input synchronizer.
REQ-003 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-004 The block SHALL have the following ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- gray_in  input  WIDTH  Gray code from the upstream Gray encoder stage, possibly from another clock domain.
- clear_err  input  1  synchronous clear of err_cnt.
- bin_out  output  WIDTH  decoded binary value, registered.
- bin_valid  output  1  one-cycle pulse when bin_out takes a new value.
- dir  output  1  direction of the last legal step: 1 = up (+1), 0 = down (-1).
- step_err  output  1  one-cycle pulse on an illegal step (more than one bit changed).
- err_cnt  output  8  saturating count of illegal steps.

Function
REQ-005 gray_in SHALL pass through a SYNC_STAGES-deep flop chain; sync_q is the last stage.
REQ-006 Decoding SHALL be b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i] for i=WIDTH-2..0.
REQ-007 The block SHALL hold gray_prev, the last accepted sync_q; a change is defined as sync_q != gray_prev.
REQ-008 The FSM SHALL have two states: INIT (after reset) and TRACK.
REQ-009 In INIT, the first cycle with sync_q != 0 SHALL set bin_out=decode(sync_q), gray_prev=sync_q, bin_valid=1, and move to TRACK; no step_err and no dir update.
REQ-010 In INIT, a sync_q of 0 SHALL cause no output change.
REQ-011 In TRACK, a change with popcount(sync_q^gray_prev)==1 SHALL update bin_out and gray_prev, pulse bin_valid, and set dir=1 if the new binary equals old+1 mod 2^WIDTH, else dir=0.
REQ-012 In TRACK, a change with popcount>1 SHALL update bin_out and gray_prev (resync), pulse bin_valid and step_err, leave dir unchanged, and increment err_cnt.
REQ-013 err_cnt SHALL saturate at 255.
REQ-014 Wrap-around SHALL be legal: gray 1000->0000 (binary 15->0) gives dir=1; 0000->1000 gives dir=0.
REQ-015 Latency SHALL be SYNC_STAGES+1 rising edges from gray_in being sampled to bin_out/bin_valid updating.
REQ-016 An unchanged sync_q SHALL hold all outputs, with bin_valid=0 and step_err=0.
REQ-017 clear_err SHALL zero err_cnt on the next edge; if an illegal step occurs in the same cycle, err_cnt SHALL become 1.
REQ-018 Back-to-back changes on consecutive cycles SHALL each produce their own bin_valid pulse; none are dropped.

Reset
REQ-019 rst_n low SHALL asynchronously clear the sync chain, gray_prev, bin_out, dir, bin_valid, step_err and err_cnt to 0, and set state INIT.
REQ-020 Release of rst_n SHALL be synchronous to clk (external reset synchronizer).
REQ-021 Reset asserted mid-operation SHALL abort any in-flight sample; the block SHALL then re-enter INIT.

Structure
REQ-022 A shared package gray_pkg SHALL hold the WIDTH default, the state typedef (INIT, TRACK), and the err_cnt width/maximum constants.
REQ-023 The decode SHALL live in one combinational sub-module, gray2bin, parameterised by WIDTH.
REQ-024 The synchronizer SHALL be inline flops with no logic between its stages.

Verification
REQ-025 Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately; first nonzero input 0110 -> bin_out=4, bin_valid pulse, step_err=0.
REQ-026 Count up: drive Gray 0..15 then 0, one value per 4 cycles -> 16 bin_valid pulses, bin_out tracks 1..15,0, dir=1, err_cnt=0.
REQ-027 Count down: 15->14 (1000->1001) -> bin_out=14, dir=0.
REQ-028 Illegal step: 0001->0010 -> step_err pulse, err_cnt=1, bin_out=3, dir unchanged.
REQ-029 Saturation/clear: 300 illegal steps -> err_cnt=255; clear_err concurrent with an illegal step -> err_cnt=1.
REQ-030 Latency: with SYNC_STAGES=3, a single change -> bin_valid exactly 4 edges after the sample edge.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code synchronizer/decoder.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 4;
    localparam int ERR_CNT_W      = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/gray_sync_decoder_gray2bin.sv
// Combinational Gray-to-binary decode, parameterised by code width.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // b[i] = b[i+1] ^ g[i] unrolls to the XOR of all Gray bits at or above i,
    // which avoids a bit-level self-reference on o_bin.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes a Gray count from another domain, decodes it to binary and
// tracks step direction and illegal (multi-bit) steps.
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 dir,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output state_t               dbg_state
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("gray_sync_decoder: SYNC_STAGES must be at least 2");
    end

    logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]     r_gray_prev;
    logic [WIDTH-1:0]     r_bin_out;
    logic                 r_bin_valid;
    logic                 r_dir;
    logic                 r_step_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    state_t               r_state;

    logic [WIDTH-1:0]     w_sync_q;
    logic [WIDTH-1:0]     w_bin_new;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_changed;
    logic                 w_single;

    // Plain flop chain: no logic between stages so each stage can resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_q  = r_sync[SYNC_STAGES-1];
    assign w_diff    = w_sync_q ^ r_gray_prev;
    assign w_changed = |w_diff;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_single  = w_changed && ((w_diff & (w_diff - WIDTH'(1))) == '0);

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .i_gray (w_sync_q),
        .o_bin  (w_bin_new)
    );

    // gray_prev is 0 in INIT, so "changed" there means "sync_q is nonzero".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_gray_prev <= '0;
            r_bin_out   <= '0;
            r_bin_valid <= 1'b0;
            r_dir       <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_bin_valid <= 1'b0;
            r_step_err  <= 1'b0;
            if (clear_err) begin
                r_err_cnt <= '0;
            end
            case (r_state)
                INIT: begin
                    if (w_changed) begin
                        r_bin_out   <= w_bin_new;
                        r_gray_prev <= w_sync_q;
                        r_bin_valid <= 1'b1;
                        r_state     <= TRACK;
                    end
                end
                TRACK: begin
                    if (w_changed) begin
                        r_bin_out   <= w_bin_new;
                        r_gray_prev <= w_sync_q;
                        r_bin_valid <= 1'b1;
                        if (w_single) begin
                            r_dir <= (w_bin_new == r_bin_out + WIDTH'(1));
                        end else begin
                            r_step_err <= 1'b1;
                            if (clear_err) begin
                                r_err_cnt <= ERR_CNT_W'(1);
                            end else if (r_err_cnt != ERR_CNT_MAX) begin
                                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bin_out   = r_bin_out;
    assign bin_valid = r_bin_valid;
    assign dir       = r_dir;
    assign step_err  = r_step_err;
    assign err_cnt   = r_err_cnt;
    assign dbg_state = r_state;

endmodule
